mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 41 ++++
 rtl/mdu.sv | 180 ++++++++++++++++++
 tb/tb_mdu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_pkg;

    localparam int W_BITS = 32;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one shift-add multiply step or one restoring-divide step
module mdu_step #(
    parameter int WIDTH = 64
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   sh,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   acc_n,
    output logic [2*WIDTH-1:0]   sh_n,
    output logic [WIDTH-1:0]     y_n
);

    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] diff;

    // Divide: acc holds the partial remainder, y the dividend/quotient, sh the divisor.
    always_comb begin
        r_shift = {acc[WIDTH-1:0], y[WIDTH-1]};
        diff    = {1'b0, r_shift} - {2'b00, sh[WIDTH-1:0]};
        acc_n   = acc;
        sh_n    = sh;
        y_n     = y;
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                acc_n = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
                y_n   = {y[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = {{(WIDTH-1){1'b0}}, r_shift};
                y_n   = {y[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (y[0]) begin
                acc_n = acc + sh;
            end
            sh_n = {sh[2*WIDTH-2:0], 1'b0};
            y_n  = {1'b0, y[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with valid/ready handshakes
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ENABLE_W = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  mdu_op_t           op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  c
);

    localparam bit HAS_W = (ENABLE_W != 0) && (WIDTH == 64);
    localparam int CW = 7;
    localparam logic [CW-1:0] LAST_FULL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_W    = CW'(W_BITS - 1);

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r = {WIDTH{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    mdu_state_t         state;
    logic [CW-1:0]      cnt, last_q;
    logic [2*WIDTH-1:0] acc, sh, acc_n, sh_n;
    logic [WIDTH-1:0]   y, y_n;
    mdu_op_t            op_q;
    logic               ok_q, div_q, neg_q, neg_r;

    logic d_w, d_div, d_sa, d_sb, d_valid;
    logic a_neg, b_neg, div_zero, ovf, sp_rem;
    logic [31:0] a_lo, b_lo;
    logic [WIDTH-1:0] a_mag, b_mag, y_init, a_ret, sp_val;

    always_comb begin
        d_w = 1'b0; d_div = 1'b0; d_sa = 1'b0; d_sb = 1'b0; d_valid = 1'b1;
        case (op)
            OP_MUL, OP_MULH:    begin d_sa = 1'b1; d_sb = 1'b1; end
            OP_MULHSU:          d_sa = 1'b1;
            OP_MULHU:           d_sa = 1'b0;
            OP_DIV, OP_REM:     begin d_div = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OP_DIVU, OP_REMU:   d_div = 1'b1;
            OP_MULW:            begin d_w = HAS_W; d_valid = HAS_W; end
            OP_DIVW, OP_REMW:   begin d_w = HAS_W; d_div = HAS_W; d_sa = HAS_W; d_sb = HAS_W; d_valid = HAS_W; end
            OP_DIVUW, OP_REMUW: begin d_w = HAS_W; d_div = HAS_W; d_valid = HAS_W; end
            default:            d_valid = 1'b0;
        endcase
    end

    // Operand magnitudes and the single-cycle divide corner cases.
    always_comb begin
        a_neg    = d_sa & (d_w ? a[31] : a[WIDTH-1]);
        b_neg    = d_sb & (d_w ? b[31] : b[WIDTH-1]);
        a_lo     = a_neg ? (32'd0 - a[31:0]) : a[31:0];
        b_lo     = b_neg ? (32'd0 - b[31:0]) : b[31:0];
        a_mag    = d_w ? WIDTH'(a_lo) : (a_neg ? ('0 - a) : a);
        b_mag    = d_w ? WIDTH'(b_lo) : (b_neg ? ('0 - b) : b);
        y_init   = d_div ? (d_w ? (a_mag << (WIDTH - W_BITS)) : a_mag) : b_mag;
        div_zero = d_div & (d_w ? (b[31:0] == 32'd0) : (b == '0));
        ovf      = d_div & d_sa & (d_w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                                       : ((a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)));
        sp_rem   = (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
        a_ret    = d_w ? sext32(a[31:0]) : a;
        if (div_zero) sp_val = sp_rem ? a_ret : '1;
        else          sp_val = sp_rem ? '0 : a_ret;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (div_q),
        .acc    (acc),
        .sh     (sh),
        .y      (y),
        .acc_n  (acc_n),
        .sh_n   (sh_n),
        .y_n    (y_n)
    );

    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   q_f, r_f, res;

    always_comb begin
        prod_f = neg_q ? ('0 - acc_n) : acc_n;
        q_f    = neg_q ? ('0 - y_n) : y_n;
        r_f    = neg_r ? ('0 - acc_n[WIDTH-1:0]) : acc_n[WIDTH-1:0];
        res    = '0;
        if (ok_q) begin
            case (op_q)
                OP_MUL:                       res = prod_f[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: res = prod_f[2*WIDTH-1:WIDTH];
                OP_MULW:                      res = sext32(prod_f[31:0]);
                OP_DIV, OP_DIVU:              res = q_f;
                OP_REM, OP_REMU:              res = r_f;
                OP_DIVW, OP_DIVUW:            res = sext32(q_f[31:0]);
                OP_REMW, OP_REMUW:            res = sext32(r_f[31:0]);
                default:                      res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_q    <= '0;
            acc       <= '0;
            sh        <= '0;
            y         <= '0;
            op_q      <= OP_MUL;
            ok_q      <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        ok_q     <= d_valid;
                        div_q    <= d_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        last_q   <= d_w ? LAST_W : LAST_FULL;
                        in_ready <= 1'b0;
                        if (div_zero || ovf) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            c         <= sp_val;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= '0;
                            acc   <= '0;
                            sh    <= (2*WIDTH)'(d_div ? b_mag : a_mag);
                            y     <= y_init;
                        end
                    end
                end
                ST_BUSY: begin
                    acc <= acc_n;
                    sh  <= sh_n;
                    y   <= y_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == last_q) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        c         <= res;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        c         <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic model
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, flush, out_valid, out_ready;
    mdu_op_t     op;
    logic [63:0] a, b, c;

    int vectors = 0;
    int miscompares = 0;

    mdu #(.WIDTH(64), .ENABLE_W(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: plain arithmetic on the architectural definitions of each opcode.
    task automatic model(input logic [3:0] opc, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] ec, output int el);
        logic [127:0] sa, sb, ua, ub, p;
        logic signed [63:0] s_a, s_b;
        logic signed [31:0] w_a, w_b;
        logic [31:0] r32;
        logic ovf64, ovf32;
        sa = {{64{av[63]}}, av}; sb = {{64{bv[63]}}, bv};
        ua = {64'd0, av};        ub = {64'd0, bv};
        s_a = av; s_b = bv; w_a = av[31:0]; w_b = bv[31:0];
        ovf64 = (av == 64'h8000_0000_0000_0000) && (bv == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (av[31:0] == 32'h8000_0000) && (bv[31:0] == 32'hFFFF_FFFF);
        ec = 64'd0; el = 65; r32 = 32'd0;
        case (opc)
            4'd0: begin p = sa * sb; ec = p[63:0]; end
            4'd1: begin p = sa * sb; ec = p[127:64]; end
            4'd2: begin p = sa * ub; ec = p[127:64]; end
            4'd3: begin p = ua * ub; ec = p[127:64]; end
            4'd4: if (bv == 0) begin ec = '1; el = 1; end
                  else if (ovf64) begin ec = av; el = 1; end
                  else ec = s_a / s_b;
            4'd5: if (bv == 0) begin ec = '1; el = 1; end else ec = av / bv;
            4'd6: if (bv == 0) begin ec = av; el = 1; end
                  else if (ovf64) begin ec = 0; el = 1; end
                  else ec = s_a % s_b;
            4'd7: if (bv == 0) begin ec = av; el = 1; end else ec = av % bv;
            4'd8: begin r32 = av[31:0] * bv[31:0]; ec = sx(r32); el = 33; end
            4'd9: begin
                el = 33;
                if (w_b == 0) begin r32 = '1; el = 1; end
                else if (ovf32) begin r32 = av[31:0]; el = 1; end
                else r32 = w_a / w_b;
                ec = sx(r32);
            end
            4'd10: begin
                el = 33;
                if (w_b == 0) begin r32 = '1; el = 1; end else r32 = av[31:0] / bv[31:0];
                ec = sx(r32);
            end
            4'd11: begin
                el = 33;
                if (w_b == 0) begin r32 = av[31:0]; el = 1; end
                else if (ovf32) begin r32 = 0; el = 1; end
                else r32 = w_a % w_b;
                ec = sx(r32);
            end
            4'd12: begin
                el = 33;
                if (w_b == 0) begin r32 = av[31:0]; el = 1; end else r32 = av[31:0] % bv[31:0];
                ec = sx(r32);
            end
            default: begin ec = 0; el = 65; end
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with it idle again.
    task automatic do_op(input logic [3:0] opc, input logic [63:0] av, input logic [63:0] bv, input int hold);
        logic [63:0] ec;
        int el, lat;
        model(opc, av, bv, ec, el);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        op = mdu_op_t'(opc); a = av; b = bv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = mdu_op_t'(4'($urandom)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        if (el > 1) check("c_zero_busy", c, 64'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", opc), 64'(lat), 64'(el));
        check($sformatf("result op%0d a=%h b=%h", opc, av, bv), c, ec);
        repeat (hold) begin
            @(negedge clk);
            check("c_hold", c, ec);
            check("in_ready_done", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
        check("out_valid_after", {63'd0, out_valid}, 64'd0);
        check("c_after", c, 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(0, 300));
            5: return {$urandom, 32'h8000_0000};
            6: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Start a long DIVU, then abort it at cycle t+10 by flush or by reset.
    task automatic abort_test(input bit use_reset);
        bit seen;
        seen = 1'b0;
        op = OP_DIVU; a = {$urandom, $urandom}; b = 64'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        if (use_reset) begin
            resetn = 1'b0;
            #1;
            check("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
            #1 resetn = 1'b1;
        end else begin
            flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        check("abort_seen_valid", {63'd0, seen}, 64'd0);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        do_op(4'd0, 64'd11, 64'd13, 0);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = OP_MUL; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_c", c, 64'd0);
        resetn = 1'b1;

        do_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        do_op(4'd3, '1, '1, 0);
        do_op(4'd1, '1, '1, 0);
        do_op(4'd4, 64'd5, 64'd0, 0);
        do_op(4'd6, 64'd5, 64'd0, 0);
        do_op(4'd4, 64'h8000_0000_0000_0000, '1, 0);
        do_op(4'd6, 64'h8000_0000_0000_0000, '1, 0);
        do_op(4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5);
        do_op(4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        do_op(4'd14, 64'd9, 64'd9, 1);

        abort_test(1'b0);
        abort_test(1'b1);

        // Flush beats an input handshake offered in the same cycle.
        op = OP_DIV; a = 64'd5; b = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept_valid", {63'd0, out_valid}, 64'd0);
        check("flush_vs_accept_ready", {63'd0, in_ready}, 64'd1);

        // Flush beats an output handshake in DONE.
        op = OP_DIV; a = 64'd5; b = 64'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("done_before_flush", {63'd0, out_valid}, 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", {63'd0, out_valid}, 64'd0);
        check("flush_done_c", c, 64'd0);

        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
